rf_writeback_scheduler: RTL and testbench
=========================================

Name: rf_writeback_scheduler

Overview:
Sequences the single register-file write port between the two superscalar issue lanes. Each cycle it accepts up to two writeback results, lane 0 ahead of lane 1. It holds them in a shared in-order queue and drains exactly one entry per cycle onto the register file's write-enable, write-address and write-data inputs. Program order of writes to the same register is preserved, and writes to x0 are discarded at the input.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2.
AW, 5, register address width.
DW, 32, data width.

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  reset, asynchronous, active-high.
wb0_valid  in  1  lane 0 writeback valid (older lane).
wb0_addr  in  AW  lane 0 destination register.
wb0_data  in  DW  lane 0 result.
wb0_ready  out  1  lane 0 may transfer.
wb1_valid  in  1  lane 1 writeback valid (younger lane).
wb1_addr  in  AW  lane 1 destination register.
wb1_data  in  DW  lane 1 result.
wb1_ready  out  1  lane 1 may transfer.
hold  in  1  suspend draining; queue contents retained.
flush  in  1  discard all queued entries.
rf_we  out  1  register-file write enable.
rf_wa  out  AW  register-file write address.
rf_wd  out  DW  register-file write data.
q_count  out  log2(DEPTH)+1  occupied entries.
q_empty  out  1  q_count==0.
q_full  out  1  q_count==DEPTH.

Behaviour:
- Reset: asynchronous, active-high. rst asserted clears rd_ptr, wr_ptr and count to 0. Outputs then read rf_we=0, rf_wa=0, rf_wd=0, q_count=0, q_empty=1, q_full=0, wb0_ready=0, wb1_ready=0. Reset mid-operation drops all pending entries with no partial write.
- Ready is a function of registered count and flush only; it never depends on either valid input.
  - wb0_ready = !flush && (DEPTH-count >= 1).
  - wb1_ready = !flush && (DEPTH-count >= 2).
  - A same-cycle pop does not add credit.
- Transfer: laneN transfers when wbN_valid && wbN_ready.
- x0 handling: a transfer with addr==0 completes the handshake but enqueues nothing.
- Enqueue order within a cycle: lane 0 entry goes first at wr_ptr, lane 1 entry next. If only one lane enqueues, it takes wr_ptr. wr_ptr advances by 0, 1 or 2 modulo DEPTH.
- Drain:
  - rf_we = !q_empty && !hold && !flush, combinational from registered state.
  - rf_wa and rf_wd show the head entry; both read 0 when rf_we=0.
  - Pop occurs on the edge where rf_we=1; rd_ptr advances by 1 modulo DEPTH.
- Latency: an entry accepted on edge N can be written no earlier than edge N+1, and only if it is at the head.
- Count update: count_next = count + pushes - pop. Simultaneous push and pop at full is legal only via the ready rules.
- Flush: synchronous. It clears pointers and count on the next edge, suppresses rf_we and both readies in the flush cycle, and blocks all acceptance. Flush takes priority over hold.
- Hold: freezes rd_ptr. Enqueue continues while space remains.
- Pointer wrap-around is modulo DEPTH and invisible externally.

Optional Feature:
Macro RF_WB_BYPASS_EN.
- Defined: adds ports byp_addr (in, AW), byp_hit (out, 1) and byp_data (out, DW).
  - byp_hit=1 when a valid queued entry, or the current head, matches byp_addr and byp_addr!=0.
  - byp_data carries the youngest matching entry.
  - Combinational from registered queue state only; incoming same-cycle writebacks are not forwarded.
  - byp_hit=0 and byp_data=0 during reset, flush or empty.
- Undefined: the ports and all compare logic are absent; the behaviour above is unchanged.

Test Plan:
- Reset: assert rst mid-stream with 3 entries queued -> all outputs zero/idle immediately, q_empty=1; no rf_we after release until new input.
- Ordering: same cycle wb0={r5,0x11}, wb1={r5,0x22} on empty queue -> edge+1 writes r5=0x11, edge+2 writes r5=0x22; final q_empty=1.
- x0 drop: wb0={r0,0xFF} with wb1={r3,0xAB} -> both handshakes complete, q_count becomes 1, only r3=0xAB is written.
- Full/backpressure, DEPTH=4, hold=1: push two pairs -> count=4, wb0_ready=0, wb1_ready=0. At count=3, wb0_ready=1 and wb1_ready=0. Release hold -> four writes on consecutive cycles, in order.
- Flush: queue 2 entries, hold=1, pulse flush with wb0_valid=1 -> no rf_we, wb0 not accepted, q_count=0 next cycle.
- Bypass (RF_WB_BYPASS_EN): queue r7=0x1, r7=0x2 with hold=1, byp_addr=7 -> byp_hit=1, byp_data=0x2. byp_addr=0 -> byp_hit=0.

Source files
------------

// File: rtl/rf_writeback_scheduler.sv
// rf_writeback_scheduler
// Shares the single register-file write port between two writeback lanes.
// Each cycle it accepts up to two results into an in-order queue, lane 0 first,
// and drains one queued entry per cycle onto the register-file write port.
// Results that target x0 complete their handshake but are never stored.
// Optional feature: define RF_WB_BYPASS_EN to add a lookup port (byp_addr,
// byp_hit, byp_data) that forwards the youngest queued value for a register.
module rf_writeback_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb0_valid,
    input  logic [AW-1:0]            wb0_addr,
    input  logic [DW-1:0]            wb0_data,
    output logic                     wb0_ready,
    input  logic                     wb1_valid,
    input  logic [AW-1:0]            wb1_addr,
    input  logic [DW-1:0]            wb1_data,
    output logic                     wb1_ready,
    input  logic                     hold,
    input  logic                     flush,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_wa,
    output logic [DW-1:0]            rf_wd,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     q_empty,
`ifdef RF_WB_BYPASS_EN
    input  logic [AW-1:0]            byp_addr,
    output logic                     byp_hit,
    output logic [DW-1:0]            byp_data,
`endif
    output logic                     q_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] ROOM1_MAX = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ROOM2_MAX = CW'(DEPTH - 2);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [PW-1:0] wr_idx1;
    logic          push0;
    logic          push1;
    logic          pop;

    // Readiness comes from registered occupancy only, so a pop in the same cycle never adds credit.
    always_comb begin
        wb0_ready = !rst && !flush && (count <= ROOM1_MAX);
        wb1_ready = !rst && !flush && (count <= ROOM2_MAX);
    end

    // Decide what is enqueued and popped this cycle; x0 targets are swallowed after the handshake.
    always_comb begin
        push0      = wb0_valid && wb0_ready && (wb0_addr != '0);
        push1      = wb1_valid && wb1_ready && (wb1_addr != '0);
        wr_idx1    = push0 ? (wr_ptr + PW'(1)) : wr_ptr;
        pop        = rf_we;
        count_next = count + CW'(push0) + CW'(push1) - CW'(pop);
    end

    // Present the head entry to the register file whenever draining is allowed.
    always_comb begin
        rf_we = !rst && !flush && !hold && (count != '0);
        rf_wa = rf_we ? addr_q[rd_ptr] : '0;
        rf_wd = rf_we ? data_q[rd_ptr] : '0;
    end

    assign q_count = count;
    assign q_empty = (count == '0);
    assign q_full  = (count == DEPTH_C);

    // Pointer and occupancy bookkeeping; flush empties the queue on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
            count  <= count_next;
        end
    end

    // Payload storage needs no reset: occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push0) begin
            addr_q[wr_ptr] <= wb0_addr;
            data_q[wr_ptr] <= wb0_data;
        end
        if (push1) begin
            addr_q[wr_idx1] <= wb1_addr;
            data_q[wr_idx1] <= wb1_data;
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic [PW-1:0] byp_idx;

    // Walk the queue oldest to youngest so the last match left standing is the youngest one.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            byp_idx = rd_ptr + PW'(i);
            if (!rst && !flush && (byp_addr != '0) && (CW'(i) < count) &&
                (addr_q[byp_idx] == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = data_q[byp_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// tb_rf_writeback_scheduler
// Directed scenarios plus a randomized run compared against a queue-based model
// of the writeback scheduler. Bypass checks are included when RF_WB_BYPASS_EN is defined.
module tb_rf_writeback_scheduler;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb0_valid;
    logic [AW-1:0] wb0_addr;
    logic [DW-1:0] wb0_data;
    logic          wb0_ready;
    logic          wb1_valid;
    logic [AW-1:0] wb1_addr;
    logic [DW-1:0] wb1_data;
    logic          wb1_ready;
    logic          hold;
    logic          flush;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [CW-1:0] q_count;
    logic          q_empty;
    logic          q_full;
`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0] byp_addr;
    logic          byp_hit;
    logic [DW-1:0] byp_data;
`endif

    entry_t mq[$];
    int errors = 0;
    int checks = 0;

    rf_writeback_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .hold(hold), .flush(flush),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .q_count(q_count), .q_empty(q_empty),
`ifdef RF_WB_BYPASS_EN
        .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data),
`endif
        .q_full(q_full)
    );

    always #5 clk = ~clk;

    // Model: a lane may transfer when the queue has room for it and no flush/reset is active.
    function automatic bit m_rdy0();
        return !rst && !flush && ((DEPTH - mq.size()) >= 1);
    endfunction

    function automatic bit m_rdy1();
        return !rst && !flush && ((DEPTH - mq.size()) >= 2);
    endfunction

    function automatic bit m_we();
        return !rst && !flush && !hold && (mq.size() > 0);
    endfunction

    task automatic set_in(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input bit h, input bit f);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
        hold = h; flush = f;
    endtask

    // Advance one clock and update the model with what the spec says happens on that edge.
    task automatic tick();
        bit a0, a1, p;
        entry_t e0, e1;
        a0 = wb0_valid && m_rdy0();
        a1 = wb1_valid && m_rdy1();
        p  = m_we();
        e0 = {wb0_addr, wb0_data};
        e1 = {wb1_addr, wb1_data};
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (p) void'(mq.pop_front());
            if (a0 && e0.a != 0) mq.push_back(e0);
            if (a1 && e1.a != 0) mq.push_back(e1);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset.rf_we got=%0h exp=0", rf_we); end
        checks++; if (rf_wa !== '0) begin errors++; $display("[TB] FAIL reset.rf_wa got=%0h exp=0", rf_wa); end
        checks++; if (rf_wd !== '0) begin errors++; $display("[TB] FAIL reset.rf_wd got=%0h exp=0", rf_wd); end
        checks++; if (q_count !== '0) begin errors++; $display("[TB] FAIL reset.q_count got=%0h exp=0", q_count); end
        checks++; if (q_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset.q_empty got=%0h exp=1", q_empty); end
        checks++; if (q_full !== 1'b0) begin errors++; $display("[TB] FAIL reset.q_full got=%0h exp=0", q_full); end
        checks++; if (wb0_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset.wb0_ready got=%0h exp=0", wb0_ready); end
        checks++; if (wb1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset.wb1_ready got=%0h exp=0", wb1_ready); end
        rst = 1'b0;
        tick();
        // Build up three entries under hold, then hit reset mid-cycle.
        set_in(1, 5'd1, 32'h31, 1, 5'd2, 32'h32, 1, 0); #1; tick();
        set_in(1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 1, 0); #1; tick();
        set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0); #1;
        checks++; if (q_count !== 3'd3) begin errors++; $display("[TB] FAIL reset.preload_count got=%0d exp=3", q_count); end
        hold = 1'b0;
        rst  = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset.mid_rf_we got=%0h exp=0", rf_we); end
        checks++; if (q_count !== '0) begin errors++; $display("[TB] FAIL reset.mid_q_count got=%0d exp=0", q_count); end
        checks++; if (q_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset.mid_q_empty got=%0h exp=1", q_empty); end
        checks++; if (wb0_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset.mid_wb0_ready got=%0h exp=0", wb0_ready); end
        checks++; if (rf_wd !== '0) begin errors++; $display("[TB] FAIL reset.mid_rf_wd got=%0h exp=0", rf_wd); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset.post_rf_we[%0d] got=%0h exp=0", k, rf_we); end
            tick();
        end
    endtask

    task automatic test_ordering();
        set_in(1, 5'd5, 32'h11, 1, 5'd5, 32'h22, 0, 0); #1;
        checks++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b1) begin errors++; $display("[TB] FAIL order.ready got=%0b%0b exp=11", wb0_ready, wb1_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL order.early_we got=%0h exp=0", rf_we); end
        tick();
        set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0); #1;
        checks++; if (q_count !== 3'd2) begin errors++; $display("[TB] FAIL order.count got=%0d exp=2", q_count); end
        checks++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd5, 32'h11}) begin errors++; $display("[TB] FAIL order.first got=%0h/%0d/%0h exp=1/5/11", rf_we, rf_wa, rf_wd); end
        tick();
        checks++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd5, 32'h22}) begin errors++; $display("[TB] FAIL order.second got=%0h/%0d/%0h exp=1/5/22", rf_we, rf_wa, rf_wd); end
        tick();
        checks++; if (q_empty !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("[TB] FAIL order.final got=empty%0h/we%0h exp=1/0", q_empty, rf_we); end
    endtask

    task automatic test_x0_drop();
        set_in(1, 5'd0, 32'hFF, 1, 5'd3, 32'hAB, 0, 0); #1;
        checks++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0.ready got=%0b%0b exp=11", wb0_ready, wb1_ready); end
        tick();
        set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0); #1;
        checks++; if (q_count !== 3'd1) begin errors++; $display("[TB] FAIL x0.count got=%0d exp=1", q_count); end
        checks++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'hAB}) begin errors++; $display("[TB] FAIL x0.write got=%0h/%0d/%0h exp=1/3/ab", rf_we, rf_wa, rf_wd); end
        tick();
        checks++; if (q_empty !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("[TB] FAIL x0.final got=empty%0h/we%0h exp=1/0", q_empty, rf_we); end
    endtask

    task automatic test_full();
        set_in(1, 5'd1, 32'hA1, 1, 5'd2, 32'hA2, 1, 0); #1; tick();
        checks++; if (q_count !== 3'd2 || wb1_ready !== 1'b1) begin errors++; $display("[TB] FAIL full.two got=cnt%0d/r1%0h exp=2/1", q_count, wb1_ready); end
        set_in(1, 5'd3, 32'hA3, 0, 5'd0, 32'h0, 1, 0); #1; tick();
        set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0); #1;
        checks++; if (q_count !== 3'd3) begin errors++; $display("[TB] FAIL full.three_count got=%0d exp=3", q_count); end
        checks++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin errors++; $display("[TB] FAIL full.three_ready got=%0b%0b exp=10", wb0_ready, wb1_ready); end
        set_in(1, 5'd4, 32'hA4, 1, 5'd6, 32'hA6, 1, 0); #1; tick();
        set_in(1, 5'd9, 32'h99, 1, 5'd9, 32'h99, 1, 0); #1;
        checks++; if (q_count !== 3'd4 || q_full !== 1'b1) begin errors++; $display("[TB] FAIL full.four got=cnt%0d/full%0h exp=4/1", q_count, q_full); end
        checks++; if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin errors++; $display("[TB] FAIL full.four_ready got=%0b%0b exp=00", wb0_ready, wb1_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL full.hold_we got=%0h exp=0", rf_we); end
        tick();
        set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0); #1;
        checks++; if (q_count !== 3'd4) begin errors++; $display("[TB] FAIL full.stuck_count got=%0d exp=4", q_count); end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'(k), 32'hA0 + 32'(k)}) begin
                errors++; $display("[TB] FAIL full.drain[%0d] got=%0h/%0d/%0h exp=1/%0d/%0h", k, rf_we, rf_wa, rf_wd, k, 32'hA0 + k);
            end
            tick();
        end
        checks++; if (q_empty !== 1'b1) begin errors++; $display("[TB] FAIL full.final_empty got=%0h exp=1", q_empty); end
    endtask

    task automatic test_flush();
        set_in(1, 5'd8, 32'h81, 1, 5'd9, 32'h91, 1, 0); #1; tick();
        set_in(1, 5'd10, 32'hA5, 0, 5'd0, 32'h0, 1, 1); #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL flush.rf_we got=%0h exp=0", rf_we); end
        checks++; if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush.ready got=%0b%0b exp=00", wb0_ready, wb1_ready); end
        tick();
        set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0); #1;
        checks++; if (q_count !== '0 || q_empty !== 1'b1) begin errors++; $display("[TB] FAIL flush.after got=cnt%0d/empty%0h exp=0/1", q_count, q_empty); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL flush.after_we got=%0h exp=0", rf_we); end
        tick();
    endtask

`ifdef RF_WB_BYPASS_EN
    task automatic test_bypass();
        byp_addr = 5'd7;
        set_in(1, 5'd7, 32'h1, 1, 5'd7, 32'h2, 1, 0); #1;
        checks++; if (byp_hit !== 1'b0) begin errors++; $display("[TB] FAIL byp.no_same_cycle got=%0h exp=0", byp_hit); end
        tick();
        set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0); #1;
        checks++; if (byp_hit !== 1'b1 || byp_data !== 32'h2) begin errors++; $display("[TB] FAIL byp.youngest got=%0h/%0h exp=1/2", byp_hit, byp_data); end
        byp_addr = 5'd0; #1;
        checks++; if (byp_hit !== 1'b0 || byp_data !== '0) begin errors++; $display("[TB] FAIL byp.x0 got=%0h/%0h exp=0/0", byp_hit, byp_data); end
        byp_addr = 5'd3; #1;
        checks++; if (byp_hit !== 1'b0) begin errors++; $display("[TB] FAIL byp.miss got=%0h exp=0", byp_hit); end
        byp_addr = 5'd7; flush = 1'b1; #1;
        checks++; if (byp_hit !== 1'b0 || byp_data !== '0) begin errors++; $display("[TB] FAIL byp.flush got=%0h/%0h exp=0/0", byp_hit, byp_data); end
        tick();
        set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0); #1;
        checks++; if (byp_hit !== 1'b0) begin errors++; $display("[TB] FAIL byp.empty got=%0h exp=0", byp_hit); end
    endtask
`endif

    task automatic test_random();
        logic [AW-1:0] exp_wa;
        logic [DW-1:0] exp_wd;
`ifdef RF_WB_BYPASS_EN
        logic          exp_hit;
        logic [DW-1:0] exp_bd;
`endif
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
`ifdef RF_WB_BYPASS_EN
            byp_addr = 5'($urandom_range(0, 7));
`endif
            #1;
            exp_wa = m_we() ? mq[0].a : '0;
            exp_wd = m_we() ? mq[0].d : '0;
            checks++; if (wb0_ready !== m_rdy0()) begin errors++; $display("[TB] FAIL rnd.wb0_ready[%0d] got=%0h exp=%0h", n, wb0_ready, m_rdy0()); end
            checks++; if (wb1_ready !== m_rdy1()) begin errors++; $display("[TB] FAIL rnd.wb1_ready[%0d] got=%0h exp=%0h", n, wb1_ready, m_rdy1()); end
            checks++; if (rf_we !== m_we()) begin errors++; $display("[TB] FAIL rnd.rf_we[%0d] got=%0h exp=%0h", n, rf_we, m_we()); end
            checks++; if (rf_wa !== exp_wa || rf_wd !== exp_wd) begin errors++; $display("[TB] FAIL rnd.head[%0d] got=%0d/%0h exp=%0d/%0h", n, rf_wa, rf_wd, exp_wa, exp_wd); end
            checks++; if (q_count !== CW'(mq.size())) begin errors++; $display("[TB] FAIL rnd.q_count[%0d] got=%0d exp=%0d", n, q_count, mq.size()); end
            checks++; if (q_empty !== (mq.size() == 0) || q_full !== (mq.size() == DEPTH)) begin errors++; $display("[TB] FAIL rnd.flags[%0d] got=e%0h/f%0h exp_size=%0d", n, q_empty, q_full, mq.size()); end
`ifdef RF_WB_BYPASS_EN
            exp_hit = 1'b0;
            exp_bd  = '0;
            if (!rst && !flush && byp_addr != 0) begin
                foreach (mq[j]) if (mq[j].a == byp_addr) begin exp_hit = 1'b1; exp_bd = mq[j].d; end
            end
            checks++; if (byp_hit !== exp_hit || byp_data !== exp_bd) begin errors++; $display("[TB] FAIL rnd.byp[%0d] got=%0h/%0h exp=%0h/%0h", n, byp_hit, byp_data, exp_hit, exp_bd); end
`endif
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
`ifdef RF_WB_BYPASS_EN
        byp_addr = '0;
`endif
        $display("[TB] starting rf_writeback_scheduler bench");
        test_reset();
        test_ordering();
        test_x0_drop();
        test_full();
        test_flush();
`ifdef RF_WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
